// File: rtl/multi_port_issue_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_port_issue_buffer_pkg
//  Purpose  : Shared constants and the first-k one-hot selector used by the
//             issue buffer for free-slot binding and static dequeue select.
//  Revision : 1.0  initial release
// ============================================================================
package multi_port_issue_buffer_pkg;

  // Dequeue selection modes
  localparam int ORDER_STATIC = 0;
  localparam int ORDER_AGE    = 1;

  // Widest vector the selector handles; callers zero-extend and truncate
  localparam int MAX_DEPTH = 64;

  // One-hot of the (k+1)-th set bit of vec, scanning from bit 0 upward.
  // Returns all zeros when vec has k or fewer bits set.
  function automatic logic [MAX_DEPTH-1:0] first_k_onehot(
    input logic [MAX_DEPTH-1:0] vec,
    input int                   k
  );
    logic [MAX_DEPTH-1:0] oh;
    int                   seen;
    oh   = '0;
    seen = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (vec[i]) begin
        if (seen == k) oh[i] = 1'b1;
        seen = seen + 1;
      end
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_port_issue_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : multi_port_issue_buffer_if
//  Purpose  : Enqueue / dequeue / wakeup bundle of the issue buffer.
//             slave = buffer side, master = producer/consumer side.
//  Revision : 1.0  initial release
// ============================================================================
interface multi_port_issue_buffer_if #(
  parameter int DEPTH      = 8,
  parameter int ENQ_WIDTH  = 2,
  parameter int DEQ_WIDTH  = 2,
  parameter int DATA_WIDTH = 32
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic                            flush_i;
  logic [ENQ_WIDTH-1:0]            enq_vld_i;
  logic [ENQ_WIDTH*DATA_WIDTH-1:0] enq_data_i;
  logic [ENQ_WIDTH-1:0]            enq_rdy_o;
  logic [DEPTH-1:0]                entry_rdy_i;
  logic [DEQ_WIDTH-1:0]            deq_vld_o;
  logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data_o;
  logic [DEQ_WIDTH*IW-1:0]         deq_idx_o;
  logic [DEQ_WIDTH-1:0]            deq_rdy_i;
  logic [DEPTH-1:0]                vld_mask_o;
  logic [CW-1:0]                   count_o;

  modport slave (
    input  flush_i, enq_vld_i, enq_data_i, entry_rdy_i, deq_rdy_i,
    output enq_rdy_o, deq_vld_o, deq_data_o, deq_idx_o, vld_mask_o, count_o
  );

  modport master (
    output flush_i, enq_vld_i, enq_data_i, entry_rdy_i, deq_rdy_i,
    input  enq_rdy_o, deq_vld_o, deq_data_o, deq_idx_o, vld_mask_o, count_o
  );

endinterface
`default_nettype wire

// File: rtl/multi_port_issue_buffer_age_matrix_picker.sv
`default_nettype none
// ============================================================================
//  Module   : age_matrix_picker
//  Purpose  : Age matrix tracking relative entry age plus iterative
//             oldest-first one-hot selection, one pick per dequeue port.
//             age_q[a][b] = 1 means entry a is older than entry b.
//  Revision : 1.0  initial release
// ============================================================================
module age_matrix_picker
  import multi_port_issue_buffer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ENQ_WIDTH = 2,
  parameter int DEQ_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DEPTH-1:0]     vld_i,
  input  logic [ENQ_WIDTH-1:0] enq_fire_i,
  input  logic [DEPTH-1:0]     enq_slot_oh_i [ENQ_WIDTH],
  input  logic [DEPTH-1:0]     cand_i,
  output logic [DEPTH-1:0]     sel_oh_o [DEQ_WIDTH]
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] older_w;
  logic [DEPTH-1:0] remaining_w;
  logic [DEPTH-1:0] older_in_rem_w;
  logic [DEPTH-1:0] is_oldest_w;

  // New entry is younger than everything already valid and than lower ports' writes
  always_comb begin
    age_d   = age_q;
    older_w = vld_i;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      if (enq_fire_i[k]) begin
        for (int s = 0; s < DEPTH; s++) begin
          if (enq_slot_oh_i[k][s]) begin
            age_d[s] = '0;
            for (int x = 0; x < DEPTH; x++) age_d[x][s] = older_w[x];
          end
        end
        older_w = older_w | enq_slot_oh_i[k];
      end
    end
  end

  // Age registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) age_q <= '{default: '0};
    else       age_q <= age_d;
  end

  // Per port: pick the candidate with no older remaining candidate, then remove it
  always_comb begin
    remaining_w    = cand_i;
    older_in_rem_w = '0;
    is_oldest_w    = '0;
    sel_oh_o       = '{default: '0};
    for (int j = 0; j < DEQ_WIDTH; j++) begin
      for (int c = 0; c < DEPTH; c++) begin
        for (int b = 0; b < DEPTH; b++) older_in_rem_w[b] = remaining_w[b] & age_q[b][c];
        is_oldest_w[c] = remaining_w[c] & ~(|older_in_rem_w);
      end
      sel_oh_o[j] = DEPTH'(first_k_onehot(MAX_DEPTH'(is_oldest_w), 0));
      remaining_w = remaining_w & ~sel_oh_o[j];
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_port_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : multi_port_issue_buffer
//  Purpose  : DEPTH-entry issue buffer with ENQ_WIDTH enqueue and DEQ_WIDTH
//             dequeue ports; static or oldest-first selection of ready entries.
//  Revision : 1.0  initial release
// ============================================================================
module multi_port_issue_buffer
  import multi_port_issue_buffer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ENQ_WIDTH  = 2,
  parameter int DEQ_WIDTH  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int AGE_ORDER  = ORDER_AGE
) (
  input  logic                      clk,
  input  logic                      rstn,
  multi_port_issue_buffer_if.slave  bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < ENQ_WIDTH) begin : g_bad_enq_width
    $error("multi_port_issue_buffer: DEPTH must be >= ENQ_WIDTH");
  end
  if (DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("multi_port_issue_buffer: DEPTH exceeds selector width");
  end

  logic [DEPTH-1:0]              vld_q, vld_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [DATA_WIDTH-1:0]         data_q [DEPTH];
  logic [DEPTH-1:0]              free_w, cand_w, enq_set_w, deq_clr_w;
  logic [DEPTH-1:0]              slot_oh_w [ENQ_WIDTH];
  logic [DEPTH-1:0]              sel_oh_w  [DEQ_WIDTH];
  logic [ENQ_WIDTH-1:0]          enq_rdy_w, enq_fire_w;
  logic [DEQ_WIDTH-1:0]          deq_vld_w, deq_fire_w;
  logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data_w;
  logic [DEQ_WIDTH*IW-1:0]       deq_idx_w;

  assign free_w = ~vld_q;
  assign cand_w = vld_q & bus.entry_rdy_i;

  // Bind enqueue port k to the k-th lowest free slot regardless of its request
  always_comb begin
    enq_set_w = '0;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      slot_oh_w[k]  = DEPTH'(first_k_onehot(MAX_DEPTH'(free_w), k));
      enq_rdy_w[k]  = rstn & ~bus.flush_i & (|slot_oh_w[k]);
      enq_fire_w[k] = bus.enq_vld_i[k] & enq_rdy_w[k];
      if (enq_fire_w[k]) enq_set_w = enq_set_w | slot_oh_w[k];
    end
  end

  if (AGE_ORDER == ORDER_AGE) begin : g_age
    age_matrix_picker #(
      .DEPTH     (DEPTH),
      .ENQ_WIDTH (ENQ_WIDTH),
      .DEQ_WIDTH (DEQ_WIDTH)
    ) u_picker (
      .clk           (clk),
      .rstn          (rstn),
      .vld_i         (vld_q),
      .enq_fire_i    (enq_fire_w),
      .enq_slot_oh_i (slot_oh_w),
      .cand_i        (cand_w),
      .sel_oh_o      (sel_oh_w)
    );
  end else begin : g_static
    // Port j takes the (j+1)-th lowest-index candidate
    always_comb begin
      for (int j = 0; j < DEQ_WIDTH; j++) begin
        sel_oh_w[j] = DEPTH'(first_k_onehot(MAX_DEPTH'(cand_w), j));
      end
    end
  end

  // Drive dequeue ports from the selection; flush discards the handshake
  always_comb begin
    deq_clr_w  = '0;
    deq_data_w = '0;
    deq_idx_w  = '0;
    deq_vld_w  = '0;
    deq_fire_w = '0;
    for (int j = 0; j < DEQ_WIDTH; j++) begin
      deq_vld_w[j]  = |sel_oh_w[j];
      deq_fire_w[j] = deq_vld_w[j] & bus.deq_rdy_i[j] & ~bus.flush_i;
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_oh_w[j][i]) begin
          deq_data_w[j*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
          deq_idx_w[j*IW +: IW]                  = IW'(i);
        end
      end
      if (deq_fire_w[j]) deq_clr_w = deq_clr_w | sel_oh_w[j];
    end
  end

  // Next valid mask and occupancy; enqueue and dequeue never target the same slot
  always_comb begin
    vld_d   = (vld_q & ~deq_clr_w) | enq_set_w;
    count_d = count_q;
    for (int k = 0; k < ENQ_WIDTH; k++) if (enq_fire_w[k]) count_d = count_d + CW'(1);
    for (int j = 0; j < DEQ_WIDTH; j++) if (deq_fire_w[j]) count_d = count_d - CW'(1);
    if (bus.flush_i) begin
      vld_d   = '0;
      count_d = '0;
    end
  end

  // Valid bits and counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  // Payload capture; contents of empty slots are don't-care so no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < ENQ_WIDTH; k++) begin
        if (enq_fire_w[k] && slot_oh_w[k][i]) data_q[i] <= bus.enq_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.enq_rdy_o  = enq_rdy_w;
  assign bus.deq_vld_o  = deq_vld_w;
  assign bus.deq_data_o = deq_data_w;
  assign bus.deq_idx_o  = deq_idx_w;
  assign bus.vld_mask_o = vld_q;
  assign bus.count_o    = count_q;

endmodule
`default_nettype wire
